pipe_run_ctrl: RTL and testbench
================================

Name: pipe_run_ctrl

Overview:
Run/halt sequencer for the 5-stage pipelined MIPS CPU. It watches IF-stage PCs against programmable breakpoints and watches ID for a decoded halt instruction, then holds the PC, drains in-flight instructions and freezes the pipeline. It releases the pipeline on a rising edge of the operator's continue_sig. Sits between the hazard unit and the PC/pipeline-register enables at CPU top level.

Parameters:
PC_W, 32, PC width in bits
NUM_BP, 2, number of breakpoint registers (1..4)
DRAIN_CYCLES, 4, cycles to let older instructions retire after a trigger (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
continue_sig  in  1  operator resume request; level, edge-detected internally
step_sig  in  1  single-step request; used only with SINGLE_STEP_EN
if_pc  in  PC_W  PC presented to instruction memory this cycle
if_pc_valid  in  1  if_pc is a real fetch (not a stall/bubble)
halt_insn  in  1  ID holds a valid decoded halt instruction
bp_wr_en  in  1  breakpoint register write strobe
bp_wr_idx  in  2  breakpoint index (must be < NUM_BP, else write ignored)
bp_wr_addr  in  PC_W  breakpoint address
bp_wr_valid  in  1  enable bit written with the address
pc_stall  out  1  hold PC register
pipe_stall  out  1  freeze all pipeline registers
flush_if  out  1  insert bubble into IF/ID
halted  out  1  pipeline is frozen in HALT
halt_cause  out  2  0 none, 1 breakpoint, 2 halt insn, 3 step
halt_pc  out  PC_W  PC captured at trigger

Behaviour:
- Reset (synchronous, active-high): state RUN, all bp_valid=0, drain counter=0, continue/step edge registers=0, skip flag=0. Outputs: pc_stall=0, pipe_stall=0, flush_if=0, halted=0, halt_cause=0, halt_pc=0. Reset in any state, including mid-DRAIN, returns to RUN the next cycle.
- Edge detection: cont_rise = continue_sig & ~continue_q. continue_q is registered every cycle. Same rule for step_sig. The pulse must be high across at least one rising clk edge.
- bp_match: if_pc_valid & some bp_valid[i] & (if_pc==bp_addr[i]) & ~skip. Same-cycle bp write takes effect the next cycle; match uses the old value.
- trigger = halt_insn | bp_match. If both fire, halt_insn wins (older instruction), cause=2.
- States:
  RUN: pc_stall = trigger (combinational); pipe_stall=0. On trigger: capture halt_pc=if_pc and halt_cause, load cnt=DRAIN_CYCLES-1, go DRAIN. The breakpointed instruction is not fetched. The halt instruction itself proceeds through the pipeline.
  DRAIN: pc_stall=1, flush_if=1, pipe_stall=0. cnt decrements each cycle; at cnt==0 go HALT.
  HALT: pc_stall=1, pipe_stall=1, halted=1, flush_if=0. On cont_rise go RESUME. Breakpoint writes are allowed here.
  RESUME (1 cycle): all stalls 0, halted=0. Set skip=1 if cause==1. Clear halt_cause to 0. Go RUN.
- skip clears after the first cycle in RUN with if_pc_valid=1, so a resumed breakpoint PC is fetched exactly once.
- cont_rise in RUN/DRAIN/RESUME is discarded; it is not queued.
- Registered outputs: halted, halt_cause, halt_pc. pc_stall/pipe_stall/flush_if decode from state (plus trigger in RUN).
- The external hazard unit ORs its own stalls in; this block never deasserts a hazard stall.

Optional Feature:
SINGLE_STEP_EN
- Defined: in HALT, step_rise (with no cont_rise) goes to RESUME with a step flag set. After exactly one cycle in RUN with if_pc_valid=1 and no other trigger, enter DRAIN with cause=3 and halt_pc = the next if_pc. cont_rise and step_rise in the same cycle: continue wins.
- Undefined: step_sig is ignored, no step logic is synthesized, and cause 3 never occurs.

Test Plan:
- Reset held 5 cycles, then released -> all outputs 0, state RUN. No stalls while if_pc walks 0x0,0x4,...
- bp0=0x00000010 valid, run -> cycle if_pc==0x10: pc_stall=1. Then 4 cycles flush_if=1, then halted=1, halt_cause=1, halt_pc=0x10.
- From that halt, 1-cycle continue_sig pulse -> RESUME 1 cycle, then fetch 0x10 once with no re-trigger and execution continues. Loop back to 0x10 -> halts again.
- halt_insn and bp_match in the same cycle -> halt_cause=2. continue_sig held high through DRAIN -> no resume until it falls and rises again.
- rst asserted during DRAIN cnt=2 -> next cycle state RUN, all outputs 0, bp_valid cleared.
- SINGLE_STEP_EN: halted at 0x10, step pulse -> one fetch at 0x10, then halted=1, halt_cause=3, halt_pc=0x14.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run/halt sequencer for the 5-stage MIPS pipeline.
//
// Watches IF-stage PCs against programmable breakpoints and ID for a decoded
// halt instruction. On a trigger it holds the PC, lets older instructions
// drain for DRAIN_CYCLES cycles while bubbling IF/ID, then freezes the whole
// pipeline. A rising edge on continue_sig releases it through a one-cycle
// RESUME state. Resuming from a breakpoint masks that breakpoint for the
// first valid fetch so the instruction is fetched exactly once.
//
// Optional feature (macro SINGLE_STEP_EN): a rising edge on step_sig while
// halted resumes for exactly one valid fetch, then halts again with cause 3.
// With the macro undefined step_sig is ignored and no step logic exists.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   continue_sig        operator resume level, edge-detected internally
//   step_sig            single-step level (SINGLE_STEP_EN only)
//   if_pc, if_pc_valid  PC at instruction memory and its fetch-valid flag
//   halt_insn           ID holds a valid decoded halt instruction
//   bp_wr_*             breakpoint register write port (idx >= NUM_BP ignored)
//   pc_stall            hold the PC register
//   pipe_stall          freeze all pipeline registers
//   flush_if            insert a bubble into IF/ID
//   halted              pipeline frozen (registered)
//   halt_cause          0 none, 1 breakpoint, 2 halt insn, 3 step (registered)
//   halt_pc             PC captured at trigger (registered)
//   dbg_state           current FSM state: 0 RUN, 1 DRAIN, 2 HALT, 3 RESUME
//
// Handshake: no valid/ready pairs; every input is sampled on each rising clk
// edge and continue/step act only on a low-to-high transition between edges.
module pipe_run_ctrl #(
    parameter int PC_W         = 32,
    parameter int NUM_BP       = 2,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            continue_sig,
    input  logic            step_sig,
    input  logic [PC_W-1:0] if_pc,
    input  logic            if_pc_valid,
    input  logic            halt_insn,
    input  logic            bp_wr_en,
    input  logic [1:0]      bp_wr_idx,
    input  logic [PC_W-1:0] bp_wr_addr,
    input  logic            bp_wr_valid,
    output logic            pc_stall,
    output logic            pipe_stall,
    output logic            flush_if,
    output logic            halted,
    output logic [1:0]      halt_cause,
    output logic [PC_W-1:0] halt_pc,
    output logic [1:0]      dbg_state
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALT   = 2'd2;
    localparam logic [1:0] S_RESUME = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic            r_cont_q;
    logic            r_skip;
    logic            r_halted;
    logic [1:0]      r_cause;
    logic [PC_W-1:0] r_hpc;
    logic [PC_W-1:0] r_bp_addr [NUM_BP];
    logic [NUM_BP-1:0] r_bp_valid;

    logic            w_cont_rise;
    logic            w_bp_hit;
    logic            w_bp_match;
    logic            w_step_hit;
    logic            w_step_rise;
    logic            w_trigger;
    logic [1:0]      w_trig_cause;

    assign w_cont_rise = continue_sig & ~r_cont_q;

`ifdef SINGLE_STEP_EN
    logic r_step_q;
    logic r_step_pend;  // resumed by step, waiting for the one valid fetch
    logic r_step_arm;   // that fetch happened; halt on the next cycle
    assign w_step_rise = step_sig & ~r_step_q;
    assign w_step_hit  = r_step_arm;
`else
    logic w_unused_step;
    assign w_unused_step = step_sig;
    assign w_step_rise   = 1'b0;
    assign w_step_hit    = 1'b0;
`endif

    // Breakpoint compare uses the registers as they were before any
    // same-cycle write; skip masks the breakpoint just resumed from.
    always_comb begin
        w_bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (r_bp_valid[i] && (r_bp_addr[i] == if_pc)) w_bp_hit = 1'b1;
        end
    end

    assign w_bp_match = if_pc_valid & w_bp_hit & ~r_skip;
    assign w_trigger  = halt_insn | w_bp_match | w_step_hit;
    // The halt instruction in ID is older than the IF fetch, so it wins.
    assign w_trig_cause = halt_insn ? 2'd2 : (w_bp_match ? 2'd1 : 2'd3);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:    if (w_trigger) w_next = S_DRAIN;
            S_DRAIN:  if (r_cnt == '0) w_next = S_HALT;
            S_HALT:   if (w_cont_rise || w_step_rise) w_next = S_RESUME;
            S_RESUME: w_next = S_RUN;
            default:  w_next = S_RUN;
        endcase
    end

    // Output decode
    always_comb begin
        pc_stall   = 1'b0;
        pipe_stall = 1'b0;
        flush_if   = 1'b0;
        case (r_state)
            S_RUN:   pc_stall = w_trigger;
            S_DRAIN: begin
                pc_stall = 1'b1;
                flush_if = 1'b1;
            end
            S_HALT: begin
                pc_stall   = 1'b1;
                pipe_stall = 1'b1;
            end
            default: ;
        endcase
    end

    // Breakpoint registers; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bp_valid <= '0;
            for (int i = 0; i < NUM_BP; i++) r_bp_addr[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_wr_en && (bp_wr_idx == 2'(i))) begin
                    r_bp_addr[i]  <= bp_wr_addr;
                    r_bp_valid[i] <= bp_wr_valid;
                end
            end
        end
    end

    // Drain counter, captured halt info, skip flag and edge detectors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_cont_q <= 1'b0;
            r_skip   <= 1'b0;
            r_halted <= 1'b0;
            r_cause  <= 2'd0;
            r_hpc    <= '0;
        end else begin
            r_cont_q <= continue_sig;
            r_halted <= (w_next == S_HALT);
            case (r_state)
                S_RUN: begin
                    if (w_trigger) begin
                        r_cnt   <= CNT_LOAD;
                        r_hpc   <= if_pc;
                        r_cause <= w_trig_cause;
                    end
                    if (if_pc_valid) r_skip <= 1'b0;
                end
                S_DRAIN: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                S_HALT: begin
                    if (w_next == S_RESUME) begin
                        r_skip  <= (r_cause == 2'd1);
                        r_cause <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SINGLE_STEP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_q    <= 1'b0;
            r_step_pend <= 1'b0;
            r_step_arm  <= 1'b0;
        end else begin
            r_step_q <= step_sig;
            if (r_state == S_RUN) begin
                if (w_trigger) begin
                    r_step_pend <= 1'b0;
                    r_step_arm  <= 1'b0;
                end else if (r_step_pend && if_pc_valid) begin
                    r_step_pend <= 1'b0;
                    r_step_arm  <= 1'b1;
                end
            end else if ((r_state == S_HALT) && (w_next == S_RESUME)) begin
                // Continue wins over a simultaneous step.
                r_step_pend <= ~w_cont_rise;
            end
        end
    end
`endif

    assign halted     = r_halted;
    assign halt_cause = r_cause;
    assign halt_pc    = r_hpc;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Testbench for pipe_run_ctrl: a small fetch-side environment model (PC that
// walks a loop 0x00..0x1C and refetches after a stall), a behavioural
// reference model of the run/halt rules, a per-cycle expected-output queue and
// a halt-event queue, both drained by an independent monitor.
module tb_pipe_run_ctrl;
  localparam int PC_W = 32;
  localparam int NUM_BP = 2;
  localparam int DRAIN_CYCLES = 4;
  localparam int EW = 6 + PC_W;
  localparam logic [PC_W-1:0] LOOP_END = 32'h1C;
`ifdef SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // ---------------- clock / reset / pins ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, continue_sig, step_sig, if_pc_valid, halt_insn;
  logic bp_wr_en, bp_wr_valid;
  logic [1:0] bp_wr_idx;
  logic [PC_W-1:0] if_pc, bp_wr_addr;
  logic pc_stall, pipe_stall, flush_if, halted;
  logic [1:0] halt_cause, dbg_state;
  logic [PC_W-1:0] halt_pc;

  pipe_run_ctrl #(.PC_W(PC_W), .NUM_BP(NUM_BP), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst(rst), .continue_sig(continue_sig), .step_sig(step_sig),
    .if_pc(if_pc), .if_pc_valid(if_pc_valid), .halt_insn(halt_insn),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr),
    .bp_wr_valid(bp_wr_valid), .pc_stall(pc_stall), .pipe_stall(pipe_stall),
    .flush_if(flush_if), .halted(halted), .halt_cause(halt_cause),
    .halt_pc(halt_pc), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [PC_W+1:0] evt_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Phase of the sequencer, expressed as plain flags and a countdown.
  bit m_draining, m_frozen, m_resuming;
  int m_drain_left;
  bit m_skip, m_cont_q, m_step_q, m_step_pend, m_step_arm;
  logic [1:0] m_cause;
  logic [PC_W-1:0] m_pc;
  bit m_bp_v[NUM_BP];
  logic [PC_W-1:0] m_bp_a[NUM_BP];

  task automatic model_reset();
    m_draining = 0; m_frozen = 0; m_resuming = 0; m_drain_left = 0;
    m_skip = 0; m_cont_q = 0; m_step_q = 0; m_step_pend = 0; m_step_arm = 0;
    m_cause = 2'd0; m_pc = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      m_bp_v[i] = 0;
      m_bp_a[i] = '0;
    end
  endtask

  function automatic bit model_running();
    return !m_draining && !m_frozen && !m_resuming;
  endfunction

  task automatic model_eval(output bit trig, output logic [1:0] cause);
    bit hit;
    hit = 0;
    for (int i = 0; i < NUM_BP; i++)
      if (m_bp_v[i] && m_bp_a[i] == if_pc) hit = 1;
    hit = hit && if_pc_valid && !m_skip;
    trig = halt_insn || hit || (STEP_EN && m_step_arm);
    cause = halt_insn ? 2'd2 : (hit ? 2'd1 : 2'd3);
  endtask

  task automatic push_expect();
    bit trig;
    logic [1:0] cause;
    bit e_pcs;
    model_eval(trig, cause);
    e_pcs = model_running() ? trig : (m_draining || m_frozen);
    exp_q.push_back({e_pcs, m_frozen, m_draining, m_frozen, m_cause, m_pc});
  endtask

  task automatic model_update();
    bit trig, c_rise, s_rise;
    logic [1:0] cause;
    if (rst) begin
      model_reset();
      return;
    end
    c_rise = continue_sig && !m_cont_q;
    s_rise = step_sig && !m_step_q;
    model_eval(trig, cause);
    if (model_running()) begin
      if (trig) begin
        m_draining = 1; m_drain_left = DRAIN_CYCLES - 1;
        m_pc = if_pc; m_cause = cause;
        m_step_pend = 0; m_step_arm = 0;
      end else if (m_step_pend && if_pc_valid) begin
        m_step_pend = 0; m_step_arm = 1;
      end
      if (if_pc_valid) m_skip = 0;
    end else if (m_draining) begin
      if (m_drain_left == 0) begin
        m_draining = 0; m_frozen = 1;
        evt_q.push_back({m_cause, m_pc});
      end else begin
        m_drain_left--;
      end
    end else if (m_frozen) begin
      if (c_rise || (STEP_EN && s_rise)) begin
        m_frozen = 0; m_resuming = 1;
        m_skip = (m_cause == 2'd1);
        m_cause = 2'd0;
        m_step_pend = STEP_EN && !c_rise;
      end
    end else begin
      m_resuming = 0;
    end
    m_cont_q = continue_sig;
    m_step_q = step_sig;
    for (int i = 0; i < NUM_BP; i++)
      if (bp_wr_en && int'(bp_wr_idx) == i) begin
        m_bp_v[i] = bp_wr_valid;
        m_bp_a[i] = bp_wr_addr;
      end
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_e;
  logic [PC_W+1:0] mon_evt;
  bit mon_prev_halted = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({pc_stall, pipe_stall, flush_if, halted, halt_cause, halt_pc} !== mon_e) begin
        errors++;
        $display("FAIL cycle_out t=%0t got stall/pipe/flush/halted/cause/pc=%b%b%b%b/%0d/%h exp=%b%b%b%b/%0d/%h",
                 $time, pc_stall, pipe_stall, flush_if, halted, halt_cause, halt_pc,
                 mon_e[EW-1], mon_e[EW-2], mon_e[EW-3], mon_e[EW-4], mon_e[PC_W+1:PC_W], mon_e[PC_W-1:0]);
      end
    end
    if (halted === 1'b1 && !mon_prev_halted) begin
      checks++;
      if (evt_q.size() == 0) begin
        errors++;
        $display("FAIL halt_event t=%0t got cause=%0d pc=%h exp no halt", $time, halt_cause, halt_pc);
      end else begin
        mon_evt = evt_q.pop_front();
        if ({halt_cause, halt_pc} !== mon_evt) begin
          errors++;
          $display("FAIL halt_event t=%0t got cause=%0d pc=%h exp cause=%0d pc=%h",
                   $time, halt_cause, halt_pc, mon_evt[PC_W+1:PC_W], mon_evt[PC_W-1:0]);
        end
      end
    end
    mon_prev_halted = (halted === 1'b1);
  end

  // ---------------- driver ----------------
  bit s_pcst, s_stall, s_halted, s_flush;

  task automatic env_advance();
    if (rst) begin
      if_pc = '0;
      if_pc_valid = 1'b1;
    end else begin
      if (if_pc_valid && !s_pcst) if_pc = (if_pc == LOOP_END) ? '0 : if_pc + 4;
      if_pc_valid = !s_stall && ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic clk1();
    push_expect();
    @(negedge clk);
    s_pcst = pc_stall;
    s_stall = pc_stall | pipe_stall;
    s_halted = halted;
    s_flush = flush_if;
    @(posedge clk);
    model_update();
    #1;
    env_advance();
    bp_wr_en = 1'b0;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  int flush_cnt;
  task automatic wait_halted(int max_cycles);
    bit seen;
    seen = 0;
    flush_cnt = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      clk1();
      if (s_flush) flush_cnt++;
      if (s_halted) seen = 1;
    end
    chk("halt_within_budget", 64'(seen), 64'd1);
  endtask

  task automatic write_bp(int idx, logic [PC_W-1:0] addr, bit v);
    bp_wr_en = 1'b1;
    bp_wr_idx = 2'(idx);
    bp_wr_addr = addr;
    bp_wr_valid = v;
    clk1();
  endtask

  task automatic pulse_continue();
    continue_sig = 1'b1;
    clk1();
    continue_sig = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int halts_seen;
  bit done;

  initial begin
    rst = 1; continue_sig = 0; step_sig = 0; halt_insn = 0;
    bp_wr_en = 0; bp_wr_idx = 0; bp_wr_addr = '0; bp_wr_valid = 0;
    if_pc = '0; if_pc_valid = 1;
    model_reset();
    @(posedge clk);
    #1;
    repeat (5) clk1();
    rst = 0;
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_cause", 64'(halt_cause), 64'd0);
    chk("reset_halt_pc", 64'(halt_pc), 64'd0);
    repeat (12) clk1();

    // Breakpoint at 0x10: drain then halt with cause 1.
    write_bp(0, 32'h10, 1'b1);
    wait_halted(80);
    chk("bp_drain_cycles", 64'(flush_cnt), 64'(DRAIN_CYCLES));
    chk("bp_cause", 64'(halt_cause), 64'd1);
    chk("bp_halt_pc", 64'(halt_pc), 64'h10);
    chk("bp_pipe_stall", 64'(pipe_stall), 64'd1);
    repeat (3) clk1();
    pulse_continue();
    chk("resume_pc_stall", 64'(pc_stall), 64'd0);
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_cause", 64'(halt_cause), 64'd0);
    // Loop comes back round to 0x10 and halts again.
    wait_halted(80);
    chk("bp_again_pc", 64'(halt_pc), 64'h10);
    pulse_continue();

    // halt_insn together with the breakpoint: cause 2; continue held high.
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      halt_insn = (if_pc == 32'h10) && if_pc_valid && model_running() && !m_skip;
      if (halt_insn) begin
        continue_sig = 1'b1;
        done = 1;
      end
      clk1();
      halt_insn = 1'b0;
    end
    chk("both_trigger_reached", 64'(done), 64'd1);
    wait_halted(20);
    chk("both_cause", 64'(halt_cause), 64'd2);
    chk("both_halt_pc", 64'(halt_pc), 64'h10);
    repeat (3) clk1();
    chk("held_continue_no_resume", 64'(halted), 64'd1);
    continue_sig = 1'b0;
    clk1();
    pulse_continue();
    chk("continue_after_fall", 64'(halted), 64'd0);

    // Reset while draining with the counter at 2.
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (m_draining && m_drain_left == 2) begin
        rst = 1'b1;
        done = 1;
      end
      clk1();
    end
    rst = 1'b0;
    chk("drain_rst_reached", 64'(done), 64'd1);
    chk("drain_rst_outputs", 64'({pc_stall, pipe_stall, flush_if, halted, halt_cause, halt_pc}), 64'd0);
    halts_seen = 0;
    for (int i = 0; i < 24; i++) begin
      clk1();
      if (s_halted || s_pcst) halts_seen++;
    end
    chk("bp_cleared_by_rst", 64'(halts_seen), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      halt_insn = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) continue_sig = ~continue_sig;
      if ($urandom_range(0, 7) == 0) step_sig = ~step_sig;
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) begin
        bp_wr_en = 1'b1;
        bp_wr_idx = 2'($urandom_range(0, 3));
        bp_wr_addr = 32'($urandom_range(0, 7)) * 4;
        bp_wr_valid = 1'($urandom_range(0, 1));
      end
      clk1();
    end
    halt_insn = 0; rst = 0; continue_sig = 0; step_sig = 0;

`ifdef SINGLE_STEP_EN
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    write_bp(0, 32'h10, 1'b1);
    wait_halted(80);
    chk("step_first_pc", 64'(halt_pc), 64'h10);
    step_sig = 1'b1;
    clk1();
    step_sig = 1'b0;
    wait_halted(40);
    chk("step_cause", 64'(halt_cause), 64'd3);
    chk("step_halt_pc", 64'(halt_pc), 64'h14);
    pulse_continue();
`endif

    repeat (4) clk1();
    chk("evt_queue_drained", 64'(evt_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
